// File: rtl/mouse_proximity_scheduler_pkg.sv
// ============================================================================
// mouse_proximity_scheduler_pkg : fixed-point constants and scheduler FSM states
// Rev 1.0
// ============================================================================
`default_nettype none

package mouse_proximity_scheduler_pkg;

  localparam int unsigned c_frac_bits    = 12;
  localparam int unsigned c_close_radius = 20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mouse_proximity_scheduler_proximity_test.sv
// ============================================================================
// proximity_test : combinational closeness / horizontal-direction test of one point
// Rev 1.0
// ============================================================================
`default_nettype none

module proximity_test
  import mouse_proximity_scheduler_pkg::*;
#(
  parameter int unsigned FRAC_BITS    = c_frac_bits,
  parameter int unsigned CLOSE_RADIUS = c_close_radius
) (
  input  logic [31:0] i_ref_x,
  input  logic [31:0] i_ref_y,
  input  logic [31:0] i_pt_x,
  input  logic [31:0] i_pt_y,
  input  logic        i_active,
  output logic        o_close,
  output logic        o_dir
);

  logic [31:0] w_dx;
  logic [31:0] w_dy;
  logic [31:0] w_adx;
  logic [31:0] w_ady;

  assign w_dx = i_pt_x - i_ref_x;
  assign w_dy = i_ref_y - i_pt_y;

  // 0x80000000 negates to itself and then fails the unsigned compare
  assign w_adx = w_dx[31] ? (32'd0 - w_dx) : w_dx;
  assign w_ady = w_dy[31] ? (32'd0 - w_dy) : w_dy;

  assign o_close = i_active
                 && ((w_adx >> FRAC_BITS) < CLOSE_RADIUS)
                 && ((w_ady >> FRAC_BITS) < CLOSE_RADIUS);
  assign o_dir   = w_dx[31];

endmodule

`default_nettype wire

// File: rtl/mouse_proximity_scheduler.sv
// ============================================================================
// mouse_proximity_scheduler : per-frame scan of the object table against the mouse
// Rev 1.0
// ============================================================================
`default_nettype none

module mouse_proximity_scheduler
  import mouse_proximity_scheduler_pkg::*;
#(
  parameter int unsigned NUM_OBJECTS  = 8,
  parameter int unsigned CLOSE_RADIUS = c_close_radius,
  parameter int unsigned FRAC_BITS    = c_frac_bits,
  parameter int unsigned IDX_W        = $clog2(NUM_OBJECTS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_start,
  input  logic [31:0]                        i_x_mouse,
  input  logic [31:0]                        i_y_mouse,
  output logic [IDX_W-1:0]                   o_obj_idx,
  input  logic [31:0]                        i_obj_x,
  input  logic [31:0]                        i_obj_y,
  input  logic                               i_obj_active,
  output logic                               o_busy,
  output logic                               o_done,
  output logic [NUM_OBJECTS-1:0]             o_close_mask,
  output logic [NUM_OBJECTS-1:0]             o_dir_mask,
  output logic [$clog2(NUM_OBJECTS+1)-1:0]   o_close_count,
  output logic                               o_any_close
);

  localparam int unsigned CNT_W = $clog2(NUM_OBJECTS + 1);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_OBJECTS - 1);

  state_t                 r_state;
  logic [31:0]            r_x_l;
  logic [31:0]            r_y_l;
  logic [IDX_W-1:0]       r_obj_idx;
  logic                   r_iss_vld;
  logic                   r_cap_vld;
  logic [IDX_W-1:0]       r_cap_idx;
  logic [NUM_OBJECTS-1:0] r_close_w;
  logic [NUM_OBJECTS-1:0] r_dir_w;
  logic                   r_busy;
  logic                   r_done;
  logic [NUM_OBJECTS-1:0] r_close_mask;
  logic [NUM_OBJECTS-1:0] r_dir_mask;
  logic [CNT_W-1:0]       r_close_count;
  logic                   r_any_close;

  logic                   w_close;
  logic                   w_dir;
  logic [NUM_OBJECTS-1:0] w_close_nxt;
  logic [NUM_OBJECTS-1:0] w_dir_nxt;
  logic [CNT_W-1:0]       w_count;

  proximity_test #(
    .FRAC_BITS    (FRAC_BITS),
    .CLOSE_RADIUS (CLOSE_RADIUS)
  ) u_proximity_test (
    .i_ref_x  (r_x_l),
    .i_ref_y  (r_y_l),
    .i_pt_x   (i_obj_x),
    .i_pt_y   (i_obj_y),
    .i_active (i_obj_active),
    .o_close  (w_close),
    .o_dir    (w_dir)
  );

  // Working masks with the object returned this cycle merged in, so the
  // last capture can go straight to the result registers.
  always_comb begin
    w_close_nxt            = r_close_w;
    w_dir_nxt              = r_dir_w;
    w_close_nxt[r_cap_idx] = w_close;
    w_dir_nxt[r_cap_idx]   = w_dir;
  end

  always_comb begin
    w_count = '0;
    for (int i = 0; i < int'(NUM_OBJECTS); i++) begin
      w_count = w_count + CNT_W'(w_close_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_x_l         <= '0;
      r_y_l         <= '0;
      r_obj_idx     <= '0;
      r_iss_vld     <= 1'b0;
      r_cap_vld     <= 1'b0;
      r_cap_idx     <= '0;
      r_close_w     <= '0;
      r_dir_w       <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_close_mask  <= '0;
      r_dir_mask    <= '0;
      r_close_count <= '0;
      r_any_close   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_x_l     <= i_x_mouse;
            r_y_l     <= i_y_mouse;
            r_close_w <= '0;
            r_dir_w   <= '0;
            r_obj_idx <= '0;
            r_iss_vld <= 1'b1;
            r_cap_vld <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= RUN;
          end
        end
        RUN: begin
          r_cap_vld <= r_iss_vld;
          r_cap_idx <= r_obj_idx;
          if (r_iss_vld) begin
            if (r_obj_idx == c_last_idx) begin
              r_iss_vld <= 1'b0;
            end else begin
              r_obj_idx <= r_obj_idx + 1'b1;
            end
          end
          if (r_cap_vld) begin
            r_close_w <= w_close_nxt;
            r_dir_w   <= w_dir_nxt;
            if (r_cap_idx == c_last_idx) begin
              r_close_mask  <= w_close_nxt;
              r_dir_mask    <= w_dir_nxt;
              r_close_count <= w_count;
              r_any_close   <= |w_close_nxt;
              r_done        <= 1'b1;
              r_busy        <= 1'b0;
              r_state       <= FINISH;
            end
          end
        end
        FINISH: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_obj_idx     = r_obj_idx;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_close_mask  = r_close_mask;
  assign o_dir_mask    = r_dir_mask;
  assign o_close_count = r_close_count;
  assign o_any_close   = r_any_close;

endmodule

`default_nettype wire

// File: tb/tb_mouse_proximity_scheduler.sv
// ============================================================================
// tb_mouse_proximity_scheduler : scoreboard bench with a behavioural proximity model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mouse_proximity_scheduler;

  localparam int N   = 8;
  localparam int IW  = 3;
  localparam int CW  = 4;
  localparam int FB  = 12;
  localparam int RAD = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [31:0]   i_x_mouse, i_y_mouse;
  logic [IW-1:0] o_obj_idx;
  logic [31:0]   i_obj_x, i_obj_y;
  logic          i_obj_active;
  logic          o_busy, o_done, o_any_close;
  logic [N-1:0]  o_close_mask, o_dir_mask;
  logic [CW-1:0] o_close_count;

  logic [31:0] tbl_x [N];
  logic [31:0] tbl_y [N];
  logic        tbl_a [N];

  typedef struct {
    logic [N-1:0] cm;
    logic [N-1:0] dm;
    int           cnt;
    int           t;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   last_done = -1;
  int   n_cmp = 0;
  int   n_bad = 0;

  mouse_proximity_scheduler #(.NUM_OBJECTS(N)) dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .i_x_mouse(i_x_mouse), .i_y_mouse(i_y_mouse),
    .o_obj_idx(o_obj_idx), .i_obj_x(i_obj_x), .i_obj_y(i_obj_y),
    .i_obj_active(i_obj_active), .o_busy(o_busy), .o_done(o_done),
    .o_close_mask(o_close_mask), .o_dir_mask(o_dir_mask),
    .o_close_count(o_close_count), .o_any_close(o_any_close)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // object table with a registered read port
  always @(posedge clk) begin
    i_obj_x      <= tbl_x[o_obj_idx];
    i_obj_y      <= tbl_y[o_obj_idx];
    i_obj_active <= tbl_a[o_obj_idx];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // integer part of |a-b| with 32-bit wrap, as a plain number
  function automatic longint int_dist(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    longint      m;
    d = a - b;
    m = longint'($signed(d));
    if (m < 0) m = -m;
    return m / (longint'(1) << FB);
  endfunction

  function automatic exp_t predict(input int t);
    exp_t e;
    logic [31:0] dx;
    e.cm = '0; e.dm = '0; e.cnt = 0; e.t = t;
    for (int i = 0; i < N; i++) begin
      dx = tbl_x[i] - i_x_mouse;
      e.dm[i] = ($signed(dx) < 0);
      e.cm[i] = tbl_a[i] && int_dist(tbl_x[i], i_x_mouse) < RAD
                         && int_dist(i_y_mouse, tbl_y[i]) < RAD;
      if (e.cm[i]) e.cnt++;
    end
    return e;
  endfunction

  // monitor: done must appear exactly when the scoreboard head is due
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (q.size() > 0 && cyc == q[0].t) begin
        e = q.pop_front();
        chk("done_timing", o_done, 1);
        if (o_done) begin
          chk("close_mask", o_close_mask, e.cm);
          chk("dir_mask", o_dir_mask, e.dm);
          chk("close_count", o_close_count, e.cnt);
          chk("any_close", o_any_close, e.cm != 0);
          chk("busy_at_done", o_busy, 0);
          chk("idx_at_done", o_obj_idx, N - 1);
        end
      end else if (o_done) begin
        chk("spurious_done", o_done, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    int guard = 0;
    while (cyc < c && guard < 1000) begin
      step();
      guard++;
    end
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    if (cyc > last_done) begin
      q.push_back(predict(cyc + N + 2));
      last_done = cyc + N + 2;
    end
    step();
    i_start = 1'b0;
  endtask

  task automatic wait_scan();
    wait_cyc(last_done + 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_close"}, o_close_mask, 0);
    chk({tag, "_dir"}, o_dir_mask, 0);
    chk({tag, "_count"}, o_close_count, 0);
    chk({tag, "_any"}, o_any_close, 0);
    chk({tag, "_idx"}, o_obj_idx, 0);
  endtask

  task automatic load_row();
    i_x_mouse = 32'h64000;
    i_y_mouse = 32'h64000;
    for (int i = 0; i < N; i++) begin
      tbl_x[i] = 32'h64000 + 32'(i) * 32'h4000;
      tbl_y[i] = 32'h64000;
      tbl_a[i] = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    last_done = cyc;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int c0;
    rst = 1'b1; i_start = 1'b0;
    load_row();
    repeat (3) step();
    rst = 1'b0;
    last_done = cyc - 1;

    // idle after reset
    repeat (10) step();
    check_zero("reset");

    // evenly spaced row of objects
    pulse_start();
    wait_scan();
    chk("s2_close", o_close_mask, 8'h1F);
    chk("s2_dir", o_dir_mask, 8'h00);
    chk("s2_count", o_close_count, 5);

    // radius boundary, objects left of the mouse
    tbl_x[3] = 32'h64000 - 32'h13FFF;
    tbl_x[4] = 32'h64000 - 32'h14000;
    pulse_start();
    wait_scan();
    chk("s3_close", o_close_mask, 8'h0F);
    chk("s3_dir", o_dir_mask, 8'h18);

    // inactive objects
    load_row();
    tbl_a[0] = 1'b0;
    tbl_a[2] = 1'b0;
    pulse_start();
    wait_scan();
    chk("s4_close", o_close_mask, 8'h1A);
    chk("s4_dir", o_dir_mask, 8'h00);

    // mouse moves and start repeats mid-scan; back-to-back start after done
    load_row();
    c0 = cyc;
    pulse_start();
    wait_cyc(c0 + 3);
    i_x_mouse = 32'h0;
    wait_cyc(c0 + 5);
    pulse_start();
    wait_scan();
    chk("s5_close", o_close_mask, 8'h1F);
    i_x_mouse = 32'h64000;
    pulse_start();
    wait_scan();

    // reset mid-scan
    c0 = cyc;
    pulse_start();
    wait_cyc(c0 + 4);
    do_reset();
    check_zero("midrst");
    repeat (N + 4) step();
    check_zero("midrst_late");
    pulse_start();
    wait_scan();
    chk("s6_close", o_close_mask, 8'h1F);

    // randomized scans
    for (int s = 0; s < 40; s++) begin
      i_x_mouse = $urandom();
      i_y_mouse = $urandom();
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 5))
          0: tbl_x[i] = $urandom();
          1: tbl_x[i] = i_x_mouse + (($urandom_range(0, 1) == 0) ? 32'h14000 : 32'hFFFEC000);
          2: tbl_x[i] = i_x_mouse + (($urandom_range(0, 1) == 0) ? 32'h13FFF : 32'hFFFEC001);
          default: tbl_x[i] = i_x_mouse + 32'($urandom_range(0, 60 << FB)) - 32'(30 << FB);
        endcase
        tbl_y[i] = ($urandom_range(0, 7) == 0) ? i_y_mouse + 32'h80000000
                 : i_y_mouse + 32'($urandom_range(0, 50 << FB)) - 32'(25 << FB);
        tbl_a[i] = ($urandom_range(0, 3) != 0);
      end
      wait_cyc(last_done + 1 + int'($urandom_range(0, 2)));
      c0 = cyc;
      pulse_start();
      if ($urandom_range(0, 2) == 0) begin
        wait_cyc(c0 + int'($urandom_range(2, N + 2)));
        i_x_mouse = $urandom();
        pulse_start();
      end
      wait_scan();
    end

    repeat (N + 5) step();
    chk("queue_drained", 64'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
